// File: rtl/wave_sel_sync.sv
// wave_sel_sync: N-channel DAC waveform selector with click-free switching.
// The active-low one-hot select is synchronised and validated. A channel change
// waits for the old waveform's midscale crossing, optionally mutes to midscale,
// and commits on the new waveform's crossing. TMO bounds every wait state.
// Optional feature macro: WAVE_SEL_MUTE_EN. When defined, the output is held at
// midscale between the two crossings. When undefined, the switch commits
// directly on the old channel's crossing and the output is never forced.
module wave_sel_sync #(
  parameter int DW  = 14,
  parameter int NCH = 4,
  parameter int TMO = 1024,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    sel_n,
  input  logic [NCH*DW-1:0] da_in,
  output logic [DW-1:0]     da_out,
  output logic [CW-1:0]     cur_ch,
  output logic              busy,
  output logic              sel_err
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TMO - 1);
`ifdef WAVE_SEL_MUTE_EN
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_OLD = 2'd1,
    S_MUTE     = 2'd2
  } state_t;

  state_t          state_q;
  logic [NCH-1:0]  sync1_q;
  logic [NCH-1:0]  sel_q;
  logic [NCH-1:0]  msb_d_q;
  logic [CW-1:0]   cur_ch_q;
  logic [CW-1:0]   pend_ch_q;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   da_out_q;
  logic            busy_q;
  logic            sel_err_q;

  logic [DW-1:0]   ch_s [NCH];
  logic [NCH-1:0]  msb_now;
  logic [NCH-1:0]  xc;
  logic [CW-1:0]   req;
  logic            valid;
  logic            tmo_hit;
  logic [TW-1:0]   timer_inc;

  // Unpack the channel bus and pick off each channel's MSB for crossing detection.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_s[k]    = da_in[k*DW +: DW];
      msb_now[k] = da_in[k*DW + DW - 1];
    end
  end

  // A crossing is any MSB change since last cycle, in either direction.
  assign xc = msb_now ^ msb_d_q;

  // Decode the synchronised select: valid only when exactly one bit is low.
  always_comb begin
    int zeros;
    zeros = 0;
    req   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!sel_q[k]) begin
        zeros = zeros + 1;
        req   = CW'(k);
      end
    end
    valid = (zeros == 1);
  end

  assign tmo_hit   = (timer_q == TMAX);
  assign timer_inc = tmo_hit ? timer_q : timer_q + 1'b1;

  // Two-flop select synchroniser and per-channel MSB history.
  // NOTE: every flop in the block, including pipeline/history flops, is async-reset
  // so a reset mid-switch leaves no stale state behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sel_q   <= '1;
      msb_d_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages distinct;
      // a blocking write here would collapse them into a single flop.
      sync1_q <= sel_n;
      sel_q   <= sync1_q;
      msb_d_q <= msb_now;
    end
  end

  // Switch FSM with registered outputs: da_out, cur_ch, busy and sel_err all
  // update together with the state so they never disagree for a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_ch_q  <= '0;
      pend_ch_q <= '0;
      timer_q   <= '0;
      da_out_q  <= '0;
      busy_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= !valid;
      case (state_q)
        S_IDLE: begin
          da_out_q <= ch_s[cur_ch_q];
          if (valid && req != cur_ch_q) begin
            state_q   <= S_WAIT_OLD;
            busy_q    <= 1'b1;
            pend_ch_q <= req;
            timer_q   <= '0;
          end
        end

        S_WAIT_OLD: begin
          if (valid && req == cur_ch_q) begin
            // Request returned to the live channel before anything moved: abort.
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            timer_q  <= '0;
            da_out_q <= ch_s[cur_ch_q];
          end else if (xc[cur_ch_q] || tmo_hit) begin
`ifdef WAVE_SEL_MUTE_EN
            state_q  <= S_MUTE;
            timer_q  <= '0;
            da_out_q <= MID;
            if (valid) pend_ch_q <= req;
`else
            // Crossing beats a same-cycle retarget: commit the old pending channel.
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            timer_q  <= '0;
            cur_ch_q <= pend_ch_q;
            da_out_q <= ch_s[pend_ch_q];
`endif
          end else begin
            if (valid) pend_ch_q <= req;
            timer_q  <= timer_inc;
            da_out_q <= ch_s[cur_ch_q];
          end
        end

`ifdef WAVE_SEL_MUTE_EN
        S_MUTE: begin
          if (xc[pend_ch_q] || tmo_hit) begin
            // Crossing beats a same-cycle retarget: commit the old pending channel.
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            timer_q  <= '0;
            cur_ch_q <= pend_ch_q;
            da_out_q <= ch_s[pend_ch_q];
          end else begin
            if (valid) pend_ch_q <= req;
            timer_q  <= timer_inc;
            da_out_q <= MID;
          end
        end
`endif

        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          timer_q  <= '0;
          da_out_q <= ch_s[cur_ch_q];
        end
      endcase
    end
  end

  assign da_out  = da_out_q;
  assign cur_ch  = cur_ch_q;
  assign busy    = busy_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_wave_sel_sync.sv
// tb_wave_sel_sync: directed bench for wave_sel_sync (DW=14, NCH=4, TMO=100).
// Expected values follow the build: muting behaviour when WAVE_SEL_MUTE_EN is
// defined, direct commit otherwise.
module tb_wave_sel_sync;

  localparam int DW  = 14;
  localparam int NCH = 4;
  localparam int TMO = 100;
`ifdef WAVE_SEL_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif
  localparam logic [DW-1:0] MID = 14'h2000;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    sel_n;
  logic [DW-1:0]     ch0, ch1, ch2, ch3;
  logic [NCH*DW-1:0] da_in;
  logic [DW-1:0]     da_out;
  logic [1:0]        cur_ch;
  logic              busy;
  logic              sel_err;

  int n_checks;
  int n_fail;

  assign da_in = {ch3, ch2, ch1, ch0};

  wave_sel_sync #(.DW(DW), .NCH(NCH), .TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel_n   (sel_n),
    .da_in   (da_in),
    .da_out  (da_out),
    .cur_ch  (cur_ch),
    .busy    (busy),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    sel_n = 4'b1110;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    sel_n = 4'b1111;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;

    // ---- Test 1: reset values, then first sample one cycle after release
    #2;
    check("rst_da_out",  da_out,  0);
    check("rst_cur_ch",  cur_ch,  0);
    check("rst_busy",    busy,    0);
    check("rst_sel_err", sel_err, 0);
    rst   = 1'b0;
    sel_n = 4'b1110;
    ch0   = 14'h1234;
    tick();
    check("t1_first_sample", da_out, 14'h1234);

    // ---- Test 4: invalid selects flag sel_err and never start a switch
    repeat (3) tick();
    check("t4_valid_sel_err", sel_err, 0);
    sel_n = 4'b1100;
    repeat (3) tick();
    check("t4_two_low_err",  sel_err, 1);
    check("t4_two_low_busy", busy,    0);
    check("t4_two_low_cur",  cur_ch,  0);
    sel_n = 4'b1111;
    repeat (3) tick();
    check("t4_none_low_err",  sel_err, 1);
    check("t4_none_low_busy", busy,    0);
    check("t4_none_low_cur",  cur_ch,  0);
    sel_n = 4'b1110;
    repeat (3) tick();
    check("t4_recover_err", sel_err, 0);

    // ---- Test 2: crossing-driven switch ch0 -> ch2
    ch0 = 14'h1000; ch2 = 14'h0800;
    do_reset();
    sel_n = 4'b1011;
    repeat (2) tick();
    check("t2_busy_not_yet", busy, 0);
    tick();
    check("t2_busy_3cyc", busy,   1);
    check("t2_old_sample", da_out, 14'h1000);
    ch0 = 14'h2100;                       // old channel crosses midscale
    tick();
    check("t2_xc_da_out", da_out, MUTE_EN ? MID : 14'h0800);
    check("t2_xc_cur",    cur_ch, MUTE_EN ? 0 : 2);
    check("t2_xc_busy",   busy,   MUTE_EN ? 1 : 0);
    repeat (9) tick();
    check("t2_hold_da_out", da_out, MUTE_EN ? MID : 14'h0800);
    check("t2_hold_cur",    cur_ch, MUTE_EN ? 0 : 2);
    ch2 = 14'h2ABC;                       // new channel crosses midscale
    tick();
    check("t2_commit_cur",  cur_ch, 2);
    check("t2_commit_busy", busy,   0);
    check("t2_commit_da",   da_out, 14'h2ABC);
    ch2 = 14'h2ABD;
    tick();
    check("t2_follow_ch2", da_out, 14'h2ABD);

    // ---- Test 3: no crossings at all, both waits run to timeout
    ch0 = 14'h0100; ch2 = 14'h0100;
    do_reset();
    sel_n = 4'b1011;
    repeat (3) tick();
    check("t3_busy", busy, 1);
    repeat (TMO - 1) tick();
    check("t3_wait_still_busy", busy,   1);
    check("t3_wait_still_cur",  cur_ch, 0);
    check("t3_wait_da_out",     da_out, 14'h0100);
    tick();
    check("t3_tmo1_da_out", da_out, MUTE_EN ? MID : 14'h0100);
    check("t3_tmo1_cur",    cur_ch, MUTE_EN ? 0 : 2);
    check("t3_tmo1_busy",   busy,   MUTE_EN ? 1 : 0);
    repeat (TMO - 1) tick();
    check("t3_mute_cur", cur_ch, MUTE_EN ? 0 : 2);
    check("t3_mute_da",  da_out, MUTE_EN ? MID : 14'h0100);
    tick();
    check("t3_final_cur",  cur_ch, 2);
    check("t3_final_busy", busy,   0);
    check("t3_final_da",   da_out, 14'h0100);

    // ---- Test 5a: retarget ch1 -> ch3 while waiting; ch1 must never commit
    ch0 = 14'h0100; ch1 = 14'h0200; ch2 = 14'h0000; ch3 = 14'h0300;
    do_reset();
    sel_n = 4'b1101;
    repeat (3) tick();
    check("t5a_busy", busy, 1);
    sel_n = 4'b0111;
    repeat (3) tick();
    ch1 = 14'h2200;                       // crossing on an intermediate channel
    tick();
    check("t5a_ch1_xc_cur",  cur_ch, 0);
    check("t5a_ch1_xc_busy", busy,   1);
    check("t5a_ch1_xc_da",   da_out, 14'h0100);
    ch0 = 14'h2100;
    tick();
    check("t5a_old_xc_cur", cur_ch, MUTE_EN ? 0 : 3);
    check("t5a_old_xc_da",  da_out, MUTE_EN ? MID : 14'h0300);
    ch3 = 14'h2300;
    tick();
    check("t5a_commit_cur",  cur_ch, 3);
    check("t5a_commit_busy", busy,   0);
    check("t5a_commit_da",   da_out, 14'h2300);

    // ---- Test 5b: request ch1 then back to ch0 before any crossing -> abort
    ch0 = 14'h0100; ch1 = 14'h0200; ch3 = 14'h0300;
    do_reset();
    sel_n = 4'b1101;
    repeat (3) tick();
    check("t5b_busy", busy, 1);
    sel_n = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5b_da_never_mid", da_out, 14'h0100);
    end
    check("t5b_abort_busy", busy,   0);
    check("t5b_abort_cur",  cur_ch, 0);

    // ---- Test 6: asynchronous reset in the middle of a switch
    ch0 = 14'h1000; ch2 = 14'h0800;
    do_reset();
    sel_n = 4'b1011;
    repeat (3) tick();
    ch0 = 14'h2100;
    tick();
    check("t6_pre_busy", busy,   MUTE_EN ? 1 : 0);
    check("t6_pre_da",   da_out, MUTE_EN ? MID : 14'h0800);
    rst = 1'b1;
    #1;
    check("t6_rst_da",   da_out, 0);
    check("t6_rst_busy", busy,   0);
    check("t6_rst_cur",  cur_ch, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
